// File: rtl/mash_pkg.sv
// rtl/mash_pkg.sv - shared constants for the MASH 1-1-1 accumulator front end
package mash_pkg;

  localparam int W_DEFAULT = 9;

  // Fibonacci LFSR for x^15 + x^14 + 1, shifted towards the MSB
  localparam int              LFSR_W     = 15;
  localparam int              LFSR_TAP_A = 14;
  localparam int              LFSR_TAP_B = 13;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;

  localparam logic [1:0] ST_ZERO = 2'b00;

  function automatic logic [1:0] st_encode(input logic carry);
    return {1'b0, carry};
  endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// rtl/mash_acc_stage.sv - one first-order accumulator with carry-in and carry-out
module mash_acc_stage
  import mash_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] addend,
  input  logic         carry_in,
  output logic [W-1:0] sum_low,
  output logic         carry_out
);

  logic [W-1:0] acc;
  logic [W:0]   sum;

  // (2^W-1) + (2^W-1) + 1 fits in W+1 bits, so one carry bit is enough
  assign sum       = {1'b0, acc} + {1'b0, addend} + {{W{1'b0}}, carry_in};
  assign sum_low   = sum[W-1:0];
  assign carry_out = sum[W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_low;
    end
  end

endmodule

// File: rtl/mash111_acc.sv
// rtl/mash111_acc.sv - word handshake, dither LFSR and three-stage carry cascade
module mash111_acc
  import mash_pkg::*;
#(
  parameter int IN_WIDTH        = 13,
  parameter int fractional_bits = W_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                din_valid,
  input  logic [IN_WIDTH-1:0]                 din,
  output logic                                din_ready,
  input  logic                                dither_en,
  output logic [1:0]                          St1,
  output logic [1:0]                          St2,
  output logic [1:0]                          St3,
  output logic [IN_WIDTH-fractional_bits-1:0] int_out,
  output logic                                out_valid
);

  localparam int W = fractional_bits;

  logic [IN_WIDTH-1:0] a_word;
  logic [IN_WIDTH-1:0] p_word;
  logic                p_full;
  logic                accept;
  logic [LFSR_W-1:0]   lfsr;
  logic                dither_bit;
  logic [W-1:0]        s1_low;
  logic [W-1:0]        s2_low;
  logic [W-1:0]        s3_low;
  logic                c1;
  logic                c2;
  logic                c3;
  logic                unused_s3;

  assign din_ready = !p_full;
  assign accept    = din_valid & din_ready;

  // Transfer and accept never coincide: accept needs p_full low, transfer needs it high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_word <= '0;
      p_word <= '0;
      p_full <= 1'b0;
    end else begin
      if (en && p_full) begin
        a_word <= p_word;
        p_full <= 1'b0;
      end
      if (accept) begin
        p_word <= din;
        p_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
    end
  end

  assign dither_bit = lfsr[0] & dither_en;

  mash_acc_stage #(.W(W)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .addend    (a_word[W-1:0]),
    .carry_in  (dither_bit),
    .sum_low   (s1_low),
    .carry_out (c1)
  );

  mash_acc_stage #(.W(W)) u_stage2 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .addend    (s1_low),
    .carry_in  (1'b0),
    .sum_low   (s2_low),
    .carry_out (c2)
  );

  mash_acc_stage #(.W(W)) u_stage3 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .addend    (s2_low),
    .carry_in  (1'b0),
    .sum_low   (s3_low),
    .carry_out (c3)
  );

  assign unused_s3 = ^s3_low;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      St1       <= ST_ZERO;
      St2       <= ST_ZERO;
      St3       <= ST_ZERO;
      int_out   <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      St1       <= st_encode(c1);
      St2       <= st_encode(c2);
      St3       <= st_encode(c3);
      int_out   <= a_word[IN_WIDTH-1:W];
      out_valid <= 1'b1;
    end else begin
      St1       <= ST_ZERO;
      St2       <= ST_ZERO;
      St3       <= ST_ZERO;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mash111_acc.sv
// tb/tb_mash111_acc.sv - randomized self-checking bench for mash111_acc
module tb_mash111_acc;

  localparam int IN_WIDTH = 13;
  localparam int W        = 9;
  localparam int MOD      = 512;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic                   din_valid;
  logic [IN_WIDTH-1:0]    din;
  logic                   din_ready;
  logic                   dither_en;
  logic [1:0]             St1;
  logic [1:0]             St2;
  logic [1:0]             St3;
  logic [IN_WIDTH-W-1:0]  int_out;
  logic                   out_valid;
  logic [11:0]            obs;

  always #5 clk = ~clk;

  mash111_acc #(.IN_WIDTH(IN_WIDTH), .fractional_bits(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din_valid (din_valid),
    .din       (din),
    .din_ready (din_ready),
    .dither_en (dither_en),
    .St1       (St1),
    .St2       (St2),
    .St3       (St3),
    .int_out   (int_out),
    .out_valid (out_valid)
  );

  assign obs = {St1, St2, St3, int_out, out_valid, din_ready};

  int n_tests = 0;
  int n_fail  = 0;

  int         m_acc1, m_acc2, m_acc3, m_lfsr, m_a, m_p;
  bit         m_pfull;
  logic [1:0] e_st1, e_st2, e_st3;
  logic [3:0] e_int;
  bit         e_ov;

  function automatic logic [11:0] exp_vec();
    return {e_st1, e_st2, e_st3, e_int, e_ov, ~m_pfull};
  endfunction

  task automatic model_reset();
    m_acc1 = 0; m_acc2 = 0; m_acc3 = 0;
    m_lfsr = 1; m_a = 0; m_p = 0; m_pfull = 0;
    e_st1 = 0; e_st2 = 0; e_st3 = 0; e_int = 0; e_ov = 0;
  endtask

  // Drive one clock cycle from a negedge and advance the reference model
  task automatic drive_cycle(input bit e, input bit v, input int word, input bit dith);
    int s1, s2, s3, d;
    bit accept;
    en = e; din_valid = v; din = word[IN_WIDTH-1:0]; dither_en = dith;
    @(posedge clk);
    accept = v && !m_pfull;
    if (e) begin
      d = dith ? (m_lfsr & 1) : 0;
      s1 = m_acc1 + (m_a % MOD) + d;  m_acc1 = s1 % MOD;
      s2 = m_acc2 + m_acc1;           m_acc2 = s2 % MOD;
      s3 = m_acc3 + m_acc2;           m_acc3 = s3 % MOD;
      e_st1 = 2'(s1 / MOD); e_st2 = 2'(s2 / MOD); e_st3 = 2'(s3 / MOD);
      e_int = 4'(m_a / MOD);
      e_ov  = 1;
      m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) & 32'h7fff;
      if (m_pfull) begin
        m_a = m_p;
        m_pfull = 0;
      end
    end else begin
      e_st1 = 0; e_st2 = 0; e_st3 = 0; e_ov = 0;
    end
    if (accept) begin
      m_p = word;
      m_pfull = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 0; din_valid = 0; dither_en = 0; din = '0;
    rst = 1;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 0; din_valid = 0; dither_en = 0; din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs !== 12'h001) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, 12'h001);
    end
    rst = 0;
  endtask

  task automatic test_reset_mid();
    int hist_ok;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1, 1, $urandom_range(8191) | 1, 0);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    drive_cycle(0, 1, 5, 0);
    #2 rst = 1;
    #1;
    n_tests++;
    if (obs !== 12'h001) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h expected %h", obs, 12'h001);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1, (i == 0), 1792, 0);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_model cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (i >= 2) begin
        hist_ok = (St1 == 2'((i - 2) % 2)) && (int_out == 4'd3);
        n_tests++;
        if (hist_ok == 0) begin
          n_fail++;
          $display("FAIL reset_mid_seq cycle %0d: got St1=%0d int=%0d expected St1=%0d int=3",
                   i, St1, int_out, (i - 2) % 2);
        end
      end
    end
  endtask

  task automatic test_exact_mean();
    int hist[512];
    int total;
    int word;
    do_reset();
    word = ($urandom_range(15) << 9) | 256;
    drive_cycle(1, 1, word, 0);
    drive_cycle(1, 0, word, 0);
    total = 0;
    for (int i = 0; i < 512; i++) begin
      drive_cycle(1, 0, word, 0);
      hist[i] = int'(St1);
      total += hist[i];
      n_tests++;
      if (obs !== exp_vec() || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL exact_mean cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (i >= 2) begin
        n_tests++;
        if (hist[i] != hist[i-2]) begin
          n_fail++;
          $display("FAIL exact_mean_period cycle %0d: got %0d expected %0d", i, hist[i], hist[i-2]);
        end
      end
    end
    n_tests++;
    if (total != 256) begin
      n_fail++;
      $display("FAIL exact_mean_total: got %0d expected 256", total);
    end
  endtask

  task automatic test_boundaries();
    int word;
    int carries;
    int pos;
    do_reset();
    word = $urandom_range(15) << 9;
    drive_cycle(1, 1, word, 0);
    for (int i = 0; i < 600; i++) begin
      drive_cycle(1, 0, word, 0);
      n_tests++;
      if ({St1, St2, St3} !== 6'd0 || obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL frac0 cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    do_reset();
    word = ($urandom_range(15) << 9) | 1;
    drive_cycle(1, 1, word, 0);
    drive_cycle(1, 0, word, 0);
    carries = 0;
    pos = -1;
    for (int i = 0; i < 520; i++) begin
      drive_cycle(1, 0, word, 0);
      if (St1 == 2'd1) begin
        carries++;
        pos = i + 1;
      end
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL frac1 cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    n_tests++;
    if (carries != 1 || pos != 512) begin
      n_fail++;
      $display("FAIL frac1_carry: got count=%0d at=%0d expected count=1 at=512", carries, pos);
    end
  endtask

  task automatic test_handshake();
    int w1, w2;
    do_reset();
    w1 = $urandom_range(8191);
    w2 = $urandom_range(8191);
    drive_cycle(0, 1, w1, 0);
    n_tests++;
    if (din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_accept: got ready=%b expected 0", din_ready);
    end
    for (int i = 1; i < 10; i++) begin
      drive_cycle(0, 1, w2, 0);
      n_tests++;
      if (din_ready !== 1'b0 || {St1, St2, St3} !== 6'd0 || out_valid !== 1'b0 ||
          obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL hs_hold cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    drive_cycle(1, 1, w2, 0);
    n_tests++;
    if (din_ready !== 1'b1 || out_valid !== 1'b1 || int_out !== 4'd0) begin
      n_fail++;
      $display("FAIL hs_transfer: got ready=%b valid=%b int=%0d expected 1 1 0",
               din_ready, out_valid, int_out);
    end
    drive_cycle(1, 1, w2, 0);
    n_tests++;
    if (din_ready !== 1'b0 || int_out !== 4'(w1 >> 9)) begin
      n_fail++;
      $display("FAIL hs_second_accept: got ready=%b int=%0d expected 0 %0d",
               din_ready, int_out, w1 >> 9);
    end
    drive_cycle(1, 0, 0, 0);
    drive_cycle(1, 0, 0, 0);
    n_tests++;
    if (int_out !== 4'(w2 >> 9) || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL hs_second_use: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_dither();
    int total;
    do_reset();
    total = 0;
    for (int i = 0; i < 32767; i++) begin
      drive_cycle(1, 0, 0, 1);
      total += int'(St1);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL dither cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    n_tests++;
    if (total != 32) begin
      n_fail++;
      $display("FAIL dither_total: got %0d expected 32", total);
    end
  endtask

  task automatic test_saturation();
    int word;
    do_reset();
    word = ($urandom_range(15) << 9) | 511;
    drive_cycle(1, 1, word, 1);
    for (int i = 0; i < 4096; i++) begin
      drive_cycle(1, 0, word, 1);
      n_tests++;
      if (St1[1] !== 1'b0 || St2[1] !== 1'b0 || St3[1] !== 1'b0 || obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL saturation cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(9) < 7, $urandom_range(1) == 1,
                  $urandom_range(8191), $urandom_range(1) == 1);
      n_tests++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_exact_mean();
    test_boundaries();
    test_handshake();
    test_dither();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
